// File: rtl/dp_sram_banked_wrap.sv
// Two-port synchronous SRAM wrapper tiling 128x32 dual-port macros to DATA_W x DEPTH,
// with bit write masks, cross-port write-through forwarding, range protection and
// collision status. Define DP_SRAM_OUT_REG_EN for a second output register stage.
module dp_sram_banked_wrap #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [AW-1:0]     A0,
  input  logic [DATA_W-1:0] D0,
  input  logic [DATA_W-1:0] WEM0,
  input  logic              WE0,
  input  logic              CE0,
  output logic [DATA_W-1:0] Q0,
  input  logic [AW-1:0]     A1,
  input  logic [DATA_W-1:0] D1,
  input  logic [DATA_W-1:0] WEM1,
  input  logic              WE1,
  input  logic              CE1,
  output logic [DATA_W-1:0] Q1,
  output logic              COLL,
  output logic [1:0]        OOR
);

  localparam int COLS = (DATA_W + 31) / 32;
  localparam int MW   = COLS * 32;
  localparam int ROWS = (DEPTH + 127) / 128;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [MW-1:0] mem [ROWS][128];

  logic          oor0, oor1, acc0, acc1, wr0, wr1, rd0, rd1, mrd0, mrd1;
  logic          same, both_wr, wen1, fwd0, fwd1;
  logic [RW-1:0] row0, row1;
  logic [6:0]    off0, off1;
  logic [MW-1:0] m0, m1, d0, d1, wmask0, wdata0;

  // Stage 0: address decode, range check, mask padding and same-address merging
  always_comb begin
    oor0    = {1'b0, A0} >= DEPTH_V;
    oor1    = {1'b0, A1} >= DEPTH_V;
    acc0    = CE0 & ~oor0;
    acc1    = CE1 & ~oor1;
    wr0     = acc0 & WE0;
    wr1     = acc1 & WE1;
    rd0     = CE0 & ~WE0;
    rd1     = CE1 & ~WE1;
    mrd0    = acc0 & ~WE0;
    mrd1    = acc1 & ~WE1;
    row0    = RW'(A0 >> 7);
    row1    = RW'(A1 >> 7);
    off0    = 7'(A0);
    off1    = 7'(A1);
    same    = (A0 == A1);
    // Padding columns get mask 1 and data 0 so unused macro bits are always written 0.
    m0      = ~MW'(~WEM0);
    m1      = ~MW'(~WEM1);
    d0      = MW'(D0);
    d1      = MW'(D1);
    both_wr = wr0 & wr1 & same;
    wen1    = wr1 & ~both_wr;
    wmask0  = both_wr ? (m0 | m1) : m0;
    wdata0  = both_wr ? ((d0 & m0) | (d1 & m1 & ~m0)) : (d0 & m0);
    fwd0    = mrd0 & wr1 & same;
    fwd1    = mrd1 & wr0 & same;
  end

  logic [MW-1:0] dout0_p1_q [ROWS];
  logic [MW-1:0] dout1_p1_q [ROWS];
  logic [MW-1:0] fdata0_p1_q, fdata1_p1_q;

  // Stage 1: macro array, per-row registered read data, forwarded write bits
  always_ff @(posedge CLK) begin
    if (wr0)  mem[row0][off0] <= (mem[row0][off0] & ~wmask0) | wdata0;
    if (wen1) mem[row1][off1] <= (mem[row1][off1] & ~m1) | (d1 & m1);
    for (int r = 0; r < ROWS; r++) begin
      if (mrd0 && row0 == RW'(r)) dout0_p1_q[r] <= mem[r][off0];
      if (mrd1 && row1 == RW'(r)) dout1_p1_q[r] <= mem[r][off1];
    end
    if (mrd0) fdata0_p1_q <= d1 & m1;
    if (mrd1) fdata1_p1_q <= d0 & m0;
  end

  logic          zero0_p1_q, zero1_p1_q, zero0_p1_d, zero1_p1_d;
  logic [RW-1:0] rsel0_p1_q, rsel1_p1_q, rsel0_p1_d, rsel1_p1_d;
  logic [MW-1:0] fmask0_p1_q, fmask1_p1_q, fmask0_p1_d, fmask1_p1_d;
  logic          coll_p1_q, coll_p1_d;
  logic [1:0]    oor_p1_q, oor_p1_d;

  always_comb begin
    zero0_p1_d  = zero0_p1_q;
    zero1_p1_d  = zero1_p1_q;
    rsel0_p1_d  = rsel0_p1_q;
    rsel1_p1_d  = rsel1_p1_q;
    fmask0_p1_d = fmask0_p1_q;
    fmask1_p1_d = fmask1_p1_q;
    if (rd0) begin
      zero0_p1_d  = oor0;
      rsel0_p1_d  = row0;
      fmask0_p1_d = fwd0 ? m1 : '0;
    end
    if (rd1) begin
      zero1_p1_d  = oor1;
      rsel1_p1_d  = row1;
      fmask1_p1_d = fwd1 ? m0 : '0;
    end
    coll_p1_d = acc0 & acc1 & same & (WE0 | WE1);
    oor_p1_d  = {CE1 & oor1, CE0 & oor0};
  end

  // Reset forces the zero flags so Q drops to 0 at once and any pending read is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      zero0_p1_q  <= 1'b1;
      zero1_p1_q  <= 1'b1;
      rsel0_p1_q  <= '0;
      rsel1_p1_q  <= '0;
      fmask0_p1_q <= '0;
      fmask1_p1_q <= '0;
      coll_p1_q   <= 1'b0;
      oor_p1_q    <= 2'b00;
    end else begin
      zero0_p1_q  <= zero0_p1_d;
      zero1_p1_q  <= zero1_p1_d;
      rsel0_p1_q  <= rsel0_p1_d;
      rsel1_p1_q  <= rsel1_p1_d;
      fmask0_p1_q <= fmask0_p1_d;
      fmask1_p1_q <= fmask1_p1_d;
      coll_p1_q   <= coll_p1_d;
      oor_p1_q    <= oor_p1_d;
    end
  end

  logic [DATA_W-1:0] q0_p1, q1_p1;

  always_comb begin
    q0_p1 = zero0_p1_q ? '0 :
            DATA_W'((dout0_p1_q[rsel0_p1_q] & ~fmask0_p1_q) | (fdata0_p1_q & fmask0_p1_q));
    q1_p1 = zero1_p1_q ? '0 :
            DATA_W'((dout1_p1_q[rsel1_p1_q] & ~fmask1_p1_q) | (fdata1_p1_q & fmask1_p1_q));
  end

`ifdef DP_SRAM_OUT_REG_EN
  logic              rvld0_p1_q, rvld1_p1_q;
  logic [DATA_W-1:0] q0_p2_q, q1_p2_q, q0_p2_d, q1_p2_d;
  logic              coll_p2_q;
  logic [1:0]        oor_p2_q;

  // Stage 2: output register; it only loads when stage 1 carried a read, so Q holds otherwise
  always_comb begin
    q0_p2_d = rvld0_p1_q ? q0_p1 : q0_p2_q;
    q1_p2_d = rvld1_p1_q ? q1_p1 : q1_p2_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rvld0_p1_q <= 1'b0;
      rvld1_p1_q <= 1'b0;
      q0_p2_q    <= '0;
      q1_p2_q    <= '0;
      coll_p2_q  <= 1'b0;
      oor_p2_q   <= 2'b00;
    end else begin
      rvld0_p1_q <= rd0;
      rvld1_p1_q <= rd1;
      q0_p2_q    <= q0_p2_d;
      q1_p2_q    <= q1_p2_d;
      coll_p2_q  <= coll_p1_q;
      oor_p2_q   <= oor_p1_q;
    end
  end

  assign Q0   = q0_p2_q;
  assign Q1   = q1_p2_q;
  assign COLL = coll_p2_q;
  assign OOR  = oor_p2_q;
`else
  assign Q0   = q0_p1;
  assign Q1   = q1_p1;
  assign COLL = coll_p1_q;
  assign OOR  = oor_p1_q;
`endif

endmodule
